// File: rtl/mem_lsu_pkg.sv
// Shared LSU types: aluop codes, FSM states, access sizes
// and the operation-to-size/sign decode table.
package mem_lsu_pkg;

  typedef logic [7:0] AluOpBus;
  typedef logic [4:0] RegAddrBus;

  localparam AluOpBus EXE_LB_OP  = 8'h20;
  localparam AluOpBus EXE_LH_OP  = 8'h21;
  localparam AluOpBus EXE_LW_OP  = 8'h23;
  localparam AluOpBus EXE_LBU_OP = 8'h24;
  localparam AluOpBus EXE_LHU_OP = 8'h25;
  localparam AluOpBus EXE_LWU_OP = 8'h26;
  localparam AluOpBus EXE_LD_OP  = 8'h27;
  localparam AluOpBus EXE_SB_OP  = 8'h28;
  localparam AluOpBus EXE_SH_OP  = 8'h29;
  localparam AluOpBus EXE_SW_OP  = 8'h2B;
  localparam AluOpBus EXE_SD_OP  = 8'h2F;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } size_e;

  typedef struct packed {
    logic  mem;
    logic  st;
    size_e size;
    logic  sext;
  } lsu_dec_t;

  function automatic lsu_dec_t lsu_decode(
    input AluOpBus op,
    input logic    is64
  );
    lsu_dec_t d;
    d = '{mem: 1'b1, st: 1'b0, size: SZ_B, sext: 1'b0};
    case (op)
      EXE_LB_OP:  d.sext = 1'b1;
      EXE_LBU_OP: d.sext = 1'b0;
      EXE_LH_OP:  begin d.size = SZ_H; d.sext = 1'b1; end
      EXE_LHU_OP: d.size = SZ_H;
      EXE_LW_OP:  begin d.size = SZ_W; d.sext = 1'b1; end
      EXE_LWU_OP: begin d.size = SZ_W; d.mem = is64; end
      EXE_LD_OP:  begin d.size = SZ_D; d.mem = is64; end
      EXE_SB_OP:  d.st = 1'b1;
      EXE_SH_OP:  begin d.size = SZ_H; d.st = 1'b1; end
      EXE_SW_OP:  begin d.size = SZ_W; d.st = 1'b1; end
      EXE_SD_OP:  begin
        d.size = SZ_D;
        d.st   = 1'b1;
        d.mem  = is64;
      end
      default:    d.mem = 1'b0;
    endcase
    return d;
  endfunction

  function automatic int unsigned size_bytes(input size_e s);
    return 32'd1 << s;
  endfunction

endpackage

// File: rtl/mem_lsu_load_align.sv
// Picks the loaded bytes out of the bus word and
// sign- or zero-extends them to the full register width.
module lsu_load_align
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic [DATA_W-1:0]          rdata_i,
  input  logic [$clog2(DATA_W/8)-1:0] off_i,
  input  size_e                      size_i,
  input  logic                       sext_i,
  output logic [DATA_W-1:0]          data_o
);

  localparam int unsigned NB = DATA_W / 8;

  int unsigned       nb;
  int unsigned       lo;
  int unsigned       bits;
  logic [DATA_W-1:0] sh;
  logic [DATA_W-1:0] mask;

  always_comb begin
    nb = size_bytes(size_i);
    if (nb > NB) nb = NB;
    // big-endian puts byte 0 in the top lane
    lo = BIG_ENDIAN ? NB - nb - 32'(off_i) : 32'(off_i);
    if (lo >= NB) lo = 0;
    bits = 8 * nb;
    sh   = rdata_i >> (8 * lo);
    mask = '1;
    if (bits < DATA_W) mask = mask >> (DATA_W - bits);
    data_o = sh & mask;
    if (sext_i && sh[bits-1]) data_o = data_o | ~mask;
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: single outstanding bus access
// with alignment check, bus timeout and writeback handshake.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  input  AluOpBus             aluop_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   store_data_i,
  input  RegAddrBus           wd_i,
  output logic                bus_req,
  output logic                bus_we,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W/8-1:0] bus_sel,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata,
  input  logic                bus_ack,
  input  logic                bus_err,
  output logic                stall_req,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wdata_o,
  output RegAddrBus           wd_o,
  output logic                excp_align,
  output logic                excp_bus,
  output logic [ADDR_W-1:0]   excp_addr
);

  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] ea_addr_q, ea_addr_d;
  logic [NB-1:0]     sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] ld_q, ld_d;
  logic              we_q, we_d;
  logic              sext_q, sext_d;
  logic              ea_q, ea_d;
  size_e             size_q, size_d;
  RegAddrBus         wd_q, wd_d;

  lsu_dec_t          dec;
  int unsigned       nb;
  int unsigned       off;
  int unsigned       lo;
  logic              misal;
  logic              fault;
  logic [DATA_W-1:0] ld_data;

  lsu_load_align #(
    .DATA_W    (DATA_W),
    .BIG_ENDIAN(BIG_ENDIAN)
  ) u_align (
    .rdata_i(bus_rdata),
    .off_i  (addr_q[OW-1:0]),
    .size_i (size_q),
    .sext_i (sext_q),
    .data_o (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      ea_addr_q <= '0;
      sel_q     <= '0;
      wdata_q   <= '0;
      ld_q      <= '0;
      we_q      <= 1'b0;
      sext_q    <= 1'b0;
      ea_q      <= 1'b0;
      size_q    <= SZ_B;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ea_addr_q <= ea_addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      ld_q      <= ld_d;
      we_q      <= we_d;
      sext_q    <= sext_d;
      ea_q      <= ea_d;
      size_q    <= size_d;
      wd_q      <= wd_d;
    end
  end

  always_comb begin
    dec   = lsu_decode(aluop_i, DATA_W == 64);
    nb    = size_bytes(dec.size);
    off   = 32'(addr_i[OW-1:0]);
    misal = (off & (nb - 1)) != 0;
    lo    = BIG_ENDIAN ? NB - nb - off : off;

    state_d   = state_q;
    cnt_d     = '0;
    addr_d    = addr_q;
    ea_addr_d = '0;
    sel_d     = sel_q;
    wdata_d   = wdata_q;
    ld_d      = ld_q;
    we_d      = we_q;
    sext_d    = sext_q;
    ea_d      = 1'b0;
    size_d    = size_q;
    wd_d      = wd_q;
    stall_req = 1'b0;
    excp_bus  = 1'b0;
    fault     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid && dec.mem) begin
          if (misal) begin
            ea_d      = 1'b1;
            ea_addr_d = addr_i;
          end else begin
            stall_req = 1'b1;
            addr_d    = addr_i;
            for (int i = 0; i < NB; i++) begin
              sel_d[i] = (i >= lo) && (i < lo + nb);
              wdata_d[8*i +: 8] = store_data_i[8*(i % nb) +: 8];
            end
            we_d    = dec.st;
            size_d  = dec.size;
            sext_d  = dec.sext;
            wd_d    = wd_i;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        stall_req = 1'b1;
        cnt_d     = cnt_q + CW'(1);
        // err wins over ack; timeout only if no ack this cycle
        fault = bus_err ||
                (!bus_ack && cnt_q == CW'(TIMEOUT - 1));
        if (fault) begin
          stall_req = 1'b0;
          excp_bus  = 1'b1;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (bus_ack) begin
          ld_d    = we_q ? '0 : ld_data;
          cnt_d   = '0;
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (rst) begin
      stall_req = 1'b0;
      excp_bus  = 1'b0;
    end
  end

  assign bus_req    = (state_q == S_WAIT);
  assign bus_we     = bus_req & we_q;
  assign bus_addr   = bus_req ? (addr_q & ~ADDR_W'(NB - 1)) : '0;
  assign bus_sel    = bus_req ? sel_q : '0;
  assign bus_wdata  = bus_req ? wdata_q : '0;
  assign wb_valid   = (state_q == S_RESP);
  assign wdata_o    = wb_valid ? ld_q : '0;
  assign wd_o       = wb_valid ? wd_q : '0;
  assign excp_align = ea_q;
  assign excp_addr  = ea_q ? ea_addr_q :
                      (excp_bus ? addr_q : '0);

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a 32-bit big-endian and a
// 64-bit little-endian instance driven by directed vectors.
module tb_mem_lsu;
  import mem_lsu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_rv, a_ack, a_err;
  AluOpBus     a_op;
  logic [31:0] a_addr, a_sd, a_rdata;
  RegAddrBus   a_wd, a_wdo_r;
  logic        a_breq, a_bwe, a_stall, a_wbv, a_ea, a_eb;
  logic [31:0] a_baddr, a_bwdata, a_wdo, a_eaddr;
  logic [3:0]  a_bsel;

  logic        b_rv, b_ack, b_err;
  AluOpBus     b_op;
  logic [31:0] b_addr;
  logic [63:0] b_sd, b_rdata;
  RegAddrBus   b_wd, b_wdo_r;
  logic        b_breq, b_bwe, b_stall, b_wbv, b_ea, b_eb;
  logic [31:0] b_baddr, b_eaddr;
  logic [63:0] b_bwdata, b_wdo;
  logic [7:0]  b_bsel;

  mem_lsu u_a (
    .clk(clk), .rst(rst), .req_valid(a_rv), .aluop_i(a_op),
    .addr_i(a_addr), .store_data_i(a_sd), .wd_i(a_wd),
    .bus_req(a_breq), .bus_we(a_bwe), .bus_addr(a_baddr),
    .bus_sel(a_bsel), .bus_wdata(a_bwdata), .bus_rdata(a_rdata),
    .bus_ack(a_ack), .bus_err(a_err), .stall_req(a_stall),
    .wb_valid(a_wbv), .wdata_o(a_wdo), .wd_o(a_wdo_r),
    .excp_align(a_ea), .excp_bus(a_eb), .excp_addr(a_eaddr)
  );

  mem_lsu #(.DATA_W(64), .BIG_ENDIAN(1'b0)) u_b (
    .clk(clk), .rst(rst), .req_valid(b_rv), .aluop_i(b_op),
    .addr_i(b_addr), .store_data_i(b_sd), .wd_i(b_wd),
    .bus_req(b_breq), .bus_we(b_bwe), .bus_addr(b_baddr),
    .bus_sel(b_bsel), .bus_wdata(b_bwdata), .bus_rdata(b_rdata),
    .bus_ack(b_ack), .bus_err(b_err), .stall_req(b_stall),
    .wb_valid(b_wbv), .wdata_o(b_wdo), .wd_o(b_wdo_r),
    .excp_align(b_ea), .excp_bus(b_eb), .excp_addr(b_eaddr)
  );

  typedef struct {
    int          kind;
    logic [63:0] val;
    RegAddrBus   wd;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;

  logic        s_breq, s_bwe, s_stall, s_wbv, s_ea, s_eb;
  logic [7:0]  s_bsel;
  logic [31:0] s_baddr, s_eaddr;
  logic [63:0] s_bwdata, s_wdo;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push(input int d, input int k,
                      input logic [63:0] v, input RegAddrBus w);
    exp_t e;
    e = '{k, v, w};
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic popq(input int d, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{-1, '0, '0};
    if (d == 0 && q0.size() > 0) begin
      e = q0.pop_front(); ok = 1'b1;
    end else if (d == 1 && q1.size() > 0) begin
      e = q1.pop_front(); ok = 1'b1;
    end
  endtask

  task automatic mon(input int d, input logic wbv,
                     input logic [63:0] wdo, input RegAddrBus wdr,
                     input logic ea, input logic eb,
                     input logic [31:0] eaddr);
    exp_t e;
    bit   ok;
    if (wbv) begin
      popq(d, e, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL d%0d_unexpected_wb: got %h expected none", d, wdo);
      end else begin
        check($sformatf("d%0d_wb_kind", d), 64'(e.kind), 64'd0);
        check($sformatf("d%0d_wb_data", d), wdo, e.val);
        check($sformatf("d%0d_wb_wd", d), 64'(wdr), 64'(e.wd));
      end
    end
    if (ea) begin
      popq(d, e, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL d%0d_unexpected_align: got %h expected none", d, eaddr);
      end else begin
        check($sformatf("d%0d_align_kind", d), 64'(e.kind), 64'd1);
        check($sformatf("d%0d_align_addr", d), 64'(eaddr), e.val);
      end
    end
    if (eb) begin
      popq(d, e, ok);
      if (!ok) begin
        tests++; fails++;
        $display("FAIL d%0d_unexpected_buserr: got %h expected none", d, eaddr);
      end else begin
        check($sformatf("d%0d_buserr_kind", d), 64'(e.kind), 64'd2);
        check($sformatf("d%0d_buserr_addr", d), 64'(eaddr), e.val);
        check($sformatf("d%0d_buserr_nowb", d), 64'(wbv), 64'd0);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_wbv, {32'b0, a_wdo}, a_wdo_r, a_ea, a_eb, a_eaddr);
    mon(1, b_wbv, b_wdo, b_wdo_r, b_ea, b_eb, b_eaddr);
  end

  task automatic snap(input int d);
    if (d == 0) begin
      s_breq = a_breq; s_bwe = a_bwe; s_stall = a_stall;
      s_wbv = a_wbv; s_ea = a_ea; s_eb = a_eb;
      s_bsel = {4'b0, a_bsel}; s_baddr = a_baddr;
      s_bwdata = {32'b0, a_bwdata}; s_wdo = {32'b0, a_wdo};
      s_eaddr = a_eaddr;
    end else begin
      s_breq = b_breq; s_bwe = b_bwe; s_stall = b_stall;
      s_wbv = b_wbv; s_ea = b_ea; s_eb = b_eb;
      s_bsel = b_bsel; s_baddr = b_baddr;
      s_bwdata = b_bwdata; s_wdo = b_wdo; s_eaddr = b_eaddr;
    end
  endtask

  task automatic drv(input int d, input logic v, input AluOpBus o,
                     input logic [31:0] ad, input logic [63:0] sd,
                     input RegAddrBus w);
    if (d == 0) begin
      a_rv = v; a_op = o; a_addr = ad; a_sd = sd[31:0]; a_wd = w;
    end else begin
      b_rv = v; b_op = o; b_addr = ad; b_sd = sd; b_wd = w;
    end
  endtask

  task automatic busdrv(input int d, input logic ack, input logic err,
                        input logic [63:0] rd);
    if (d == 0) begin
      a_ack = ack; a_err = err; a_rdata = rd[31:0];
    end else begin
      b_ack = ack; b_err = err; b_rdata = rd;
    end
  endtask

  task automatic zchk(input int d, input string tag);
    snap(d);
    check($sformatf("d%0d_%s_breq", d, tag), 64'(s_breq), 0);
    check($sformatf("d%0d_%s_stall", d, tag), 64'(s_stall), 0);
    check($sformatf("d%0d_%s_wbv", d, tag), 64'(s_wbv), 0);
    check($sformatf("d%0d_%s_ea", d, tag), 64'(s_ea), 0);
    check($sformatf("d%0d_%s_eb", d, tag), 64'(s_eb), 0);
    check($sformatf("d%0d_%s_bwe", d, tag), 64'(s_bwe), 0);
    check($sformatf("d%0d_%s_bsel", d, tag), 64'(s_bsel), 0);
    check($sformatf("d%0d_%s_baddr", d, tag), 64'(s_baddr), 0);
    check($sformatf("d%0d_%s_bwdata", d, tag), s_bwdata, 0);
    check($sformatf("d%0d_%s_wdo", d, tag), s_wdo, 0);
    check($sformatf("d%0d_%s_eaddr", d, tag), 64'(s_eaddr), 0);
  endtask

  // ackdly: WAIT cycle on which ack/err is driven, 0 = never
  task automatic access(input int d, input AluOpBus o,
                        input logic [31:0] ad, input logic [63:0] sd,
                        input RegAddrBus w, input int ackdly,
                        input logic ack, input logic err,
                        input logic [63:0] rd, input logic [7:0] esel,
                        input logic [63:0] ewd, input logic ewe,
                        input int ewait, input int estall);
    int          st;
    int          n;
    bit          done;
    logic [31:0] ebase;
    string       t;
    st = 0; n = 1; done = 1'b0;
    ebase = ad & ((d == 0) ? ~32'd3 : ~32'd7);
    t = $sformatf("d%0d_%h", d, ad);
    @(posedge clk); #1;
    drv(d, 1'b1, o, ad, sd, w);
    @(negedge clk); snap(d); st += int'(s_stall);
    @(posedge clk); #1;
    drv(d, 1'b0, 8'h00, '0, '0, '0);
    while (!done && n <= 40) begin
      if (n == ackdly) busdrv(d, ack, err, rd);
      @(negedge clk); snap(d); st += int'(s_stall);
      check({t, "_breq"}, 64'(s_breq), 1);
      check({t, "_sel"}, 64'(s_bsel), 64'(esel));
      check({t, "_baddr"}, 64'(s_baddr), 64'(ebase));
      check({t, "_bwdata"}, s_bwdata, ewd);
      check({t, "_bwe"}, 64'(s_bwe), 64'(ewe));
      done = (n == ackdly) || (s_eb === 1'b1);
      @(posedge clk); #1;
      busdrv(d, 1'b0, 1'b0, '0);
      if (!done) n++;
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL %s_complete: got no end after 40 cycles expected end", t);
    end
    check({t, "_wait_cycles"}, 64'(n), 64'(ewait));
    @(negedge clk); snap(d); st += int'(s_stall);
    check({t, "_breq_after"}, 64'(s_breq), 0);
    check({t, "_stall_cycles"}, 64'(st), 64'(estall));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drv(0, 1'b0, 8'h00, '0, '0, '0);
    drv(1, 1'b0, 8'h00, '0, '0, '0);
    busdrv(0, 1'b0, 1'b0, '0);
    busdrv(1, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    zchk(0, "rst");
    zchk(1, "rst");
    @(posedge clk); #1;
    rst = 1'b0;

    push(0, 0, 64'hFFFF_FFF0, 5'd5);
    access(0, EXE_LB_OP, 32'h1001, 64'h0, 5'd5, 2, 1'b1, 1'b0,
           64'h11F0_3344, 8'h04, 64'h0, 1'b0, 2, 3);

    push(0, 0, 64'h0, 5'd6);
    access(0, EXE_SH_OP, 32'h2002, 64'h0000_ABCD, 5'd6, 3, 1'b1,
           1'b0, 64'h0, 8'h03, 64'hABCD_ABCD, 1'b1, 3, 4);

    push(0, 0, 64'h0000_0080, 5'd7);
    access(0, EXE_LBU_OP, 32'h1003, 64'h0, 5'd7, 1, 1'b1, 1'b0,
           64'h11F0_3380, 8'h01, 64'h0, 1'b0, 1, 2);

    push(0, 0, 64'hFFFF_8123, 5'd8);
    access(0, EXE_LH_OP, 32'h1000, 64'h0, 5'd8, 1, 1'b1, 1'b0,
           64'h8123_4567, 8'h0C, 64'h0, 1'b0, 1, 2);

    push(0, 0, 64'hDEAD_BEEF, 5'd9);
    access(0, EXE_LW_OP, 32'h4004, 64'h0, 5'd9, 2, 1'b1, 1'b0,
           64'hDEAD_BEEF, 8'h0F, 64'h0, 1'b0, 2, 3);

    push(0, 0, 64'h0, 5'd10);
    access(0, EXE_SB_OP, 32'h5003, 64'h1234_5678, 5'd10, 1, 1'b1,
           1'b0, 64'h0, 8'h01, 64'h7878_7878, 1'b1, 1, 2);

    push(0, 1, 64'h3002, 5'd0);
    @(posedge clk); #1;
    drv(0, 1'b1, EXE_LW_OP, 32'h3002, '0, 5'd4);
    @(negedge clk); snap(0);
    check("d0_misal_stall", 64'(s_stall), 0);
    check("d0_misal_breq0", 64'(s_breq), 0);
    @(posedge clk); #1;
    drv(0, 1'b0, 8'h00, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); snap(0);
      check($sformatf("d0_misal_breq%0d", i + 1), 64'(s_breq), 0);
      check($sformatf("d0_misal_stall%0d", i + 1), 64'(s_stall), 0);
    end

    push(0, 2, 64'h6000, 5'd0);
    access(0, EXE_LW_OP, 32'h6000, 64'h0, 5'd11, 0, 1'b0, 1'b0,
           64'h0, 8'h0F, 64'h0, 1'b0, 15, 15);

    push(0, 2, 64'h7002, 5'd0);
    access(0, EXE_LHU_OP, 32'h7002, 64'h0, 5'd12, 2, 1'b1, 1'b1,
           64'hFFFF_FFFF, 8'h03, 64'h0, 1'b0, 2, 2);

    @(posedge clk); #1;
    drv(0, 1'b1, 8'h00, 32'h1000, '0, 5'd1);
    busdrv(0, 1'b1, 1'b0, 64'hFFFF_FFFF);
    @(negedge clk); snap(0);
    check("d0_nop_stall", 64'(s_stall), 0);
    check("d0_nop_breq", 64'(s_breq), 0);
    @(posedge clk); #1;
    drv(0, 1'b1, EXE_LWU_OP, 32'h1000, '0, 5'd1);
    @(negedge clk); snap(0);
    check("d0_lwu32_stall", 64'(s_stall), 0);
    @(posedge clk); #1;
    drv(0, 1'b0, 8'h00, '0, '0, '0);
    busdrv(0, 1'b0, 1'b0, '0);
    @(negedge clk); snap(0);
    check("d0_nop_breq_after", 64'(s_breq), 0);
    check("d0_nop_wbv_after", 64'(s_wbv), 0);

    push(1, 0, 64'h8001, 5'd11);
    access(1, EXE_LHU_OP, 32'h8006, 64'h0, 5'd11, 1, 1'b1, 1'b0,
           64'h8001_0000_0000_0000, 8'hC0, 64'h0, 1'b0, 1, 2);

    push(1, 0, 64'h0123_4567_89AB_CDEF, 5'd12);
    access(1, EXE_LD_OP, 32'h8008, 64'h0, 5'd12, 1, 1'b1, 1'b0,
           64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 1'b0, 1, 2);

    push(1, 0, 64'h0, 5'd13);
    access(1, EXE_SW_OP, 32'h800C, 64'h0000_0000_CAFE_BABE, 5'd13, 2,
           1'b1, 1'b0, 64'h0, 8'hF0, 64'hCAFE_BABE_CAFE_BABE, 1'b1,
           2, 3);

    push(1, 0, 64'hFFFF_FFFF_8000_0000, 5'd14);
    access(1, EXE_LW_OP, 32'h8004, 64'h0, 5'd14, 1, 1'b1, 1'b0,
           64'h8000_0000_1234_5678, 8'hF0, 64'h0, 1'b0, 1, 2);

    @(posedge clk); #1;
    drv(1, 1'b1, EXE_LW_OP, 32'h9000, '0, 5'd3);
    @(posedge clk); #1;
    drv(1, 1'b0, 8'h00, '0, '0, '0);
    @(negedge clk); snap(1);
    check("d1_rstwait_breq", 64'(s_breq), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); snap(1);
    check("d1_rstwait_stall", 64'(s_stall), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    zchk(1, "midrst");
    zchk(0, "midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); snap(1);
      check($sformatf("d1_postrst_breq%0d", i), 64'(s_breq), 0);
      check($sformatf("d1_postrst_wbv%0d", i), 64'(s_wbv), 0);
    end

    check("d0_queue_drained", 64'(q0.size()), 0);
    check("d1_queue_drained", 64'(q1.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
